// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1280x1024@60 VGA timing defaults, counter widths and the load-request FSM encoding.
package vga_timing_pkg;
    localparam int CW = 11;
    localparam int LW = 13;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP = 48;
    localparam int DEF_H_SYNC = 112;
    localparam int DEF_H_BP = 248;
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP = 1;
    localparam int DEF_V_SYNC = 3;
    localparam int DEF_V_BP = 38;
    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END = DEF_VS_START + DEF_V_SYNC;
    typedef enum logic [1:0] {IDLE, REQ1, REQ2} req_state_t;
    function automatic logic in_range(input logic [CW-1:0] x, input int lo, input int hi);
        return x >= CW'(lo) && x < CW'(hi);
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters with active, sync and frame-start decode (unregistered).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP
) (
    input  logic          clock_fifowriter,
    input  logic          iRST,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Reset parks on the last line so line 0 is prefetched before the first frame.
    always_ff @(posedge clock_fifowriter or posedge iRST) begin
        if (iRST) begin
            hcount <= '0;
            vcount <= CW'(V_TOTAL - 1);
        end else begin
            hcount <= hcount == CW'(H_TOTAL - 1) ? '0 : hcount + CW'(1);
            if (hcount == CW'(H_TOTAL - 1))
                vcount <= vcount == CW'(V_TOTAL - 1) ? '0 : vcount + CW'(1);
        end
    end
    assign active = hcount < CW'(H_ACTIVE) && vcount < CW'(V_ACTIVE);
    assign hs = in_range(hcount, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    assign vs = in_range(vcount, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    assign frame_start = hcount == '0 && vcount == '0;
endmodule

// File: rtl/sdram_vga_fifo_reader.sv
// sdram_vga_fifo_reader: VGA timing, line-FIFO pixel pop with VS flush, one-line-ahead SDRAM load requests.
// Optional VGA_FIFO_TEST_PATTERN_EN adds iPATTERN_SEL, an XOR test pattern that bypasses the FIFO.
module sdram_vga_fifo_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP
) (
    input  logic          clock_fifowriter,
    input  logic          iRST,
    input  logic [7:0]    iFIFO_RDATA,
    input  logic          iFIFO_EMPTY,
    output logic          oFIFO_RDEN,
    output logic [LW-1:0] oVGA_LINE_TO_LOAD,
    output logic          oVGA_LOAD_TO_FIFO_REQ,
    output logic [7:0]    oVGA_PIXEL,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_BLANK_N,
    output logic          oFRAME_START,
    output logic          oUNDERFLOW,
    input  logic          iUNDERFLOW_CLR
`ifdef VGA_FIFO_TEST_PATTERN_EN
    ,
    input  logic          iPATTERN_SEL
`endif
);
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic [CW-1:0] hcount, vcount;
    logic active, hs, vs, frame_start, pattern, show, underflow, pop_q, req_start;
    logic [7:0] pat_q;
    req_state_t state;
    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) timing (
        .clock_fifowriter(clock_fifowriter), .iRST(iRST), .hcount(hcount), .vcount(vcount),
        .active(active), .hs(hs), .vs(vs), .frame_start(frame_start)
    );
`ifdef VGA_FIFO_TEST_PATTERN_EN
    assign pattern = iPATTERN_SEL;
`else
    assign pattern = 1'b0;
`endif
    assign show = active && !iFIFO_EMPTY && !pattern;
    assign underflow = active && iFIFO_EMPTY && !pattern;
    // Popping through the VS lines drains leftovers so the next frame starts aligned.
    assign oFIFO_RDEN = (active || vs) && !iFIFO_EMPTY && !pattern;
    assign oVGA_PIXEL = pop_q ? iFIFO_RDATA : pat_q;
    // Launch one cycle early so the request is already high while hcount reads H_ACTIVE.
    assign req_start = hcount == CW'(H_ACTIVE - 1) &&
                       (vcount < CW'(V_ACTIVE - 1) || vcount == CW'(V_TOTAL - 1));
    always_ff @(posedge clock_fifowriter or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            oVGA_LOAD_TO_FIFO_REQ <= 1'b0;
            oVGA_LINE_TO_LOAD <= '0;
        end else begin
            case (state)
                IDLE: if (req_start) begin
                    state <= REQ1;
                    oVGA_LOAD_TO_FIFO_REQ <= 1'b1;
                    oVGA_LINE_TO_LOAD <= vcount == CW'(V_TOTAL - 1) ? '0 : LW'(vcount) + LW'(1);
                end
                REQ1: state <= REQ2;
                default: begin
                    state <= IDLE;
                    oVGA_LOAD_TO_FIFO_REQ <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clock_fifowriter or posedge iRST) begin
        if (iRST) begin
            oVGA_HS <= 1'b0;
            oVGA_VS <= 1'b0;
            oVGA_BLANK_N <= 1'b0;
            oFRAME_START <= 1'b0;
            oUNDERFLOW <= 1'b0;
            pop_q <= 1'b0;
            pat_q <= '0;
        end else begin
            oVGA_HS <= hs;
            oVGA_VS <= vs;
            oVGA_BLANK_N <= active;
            oFRAME_START <= frame_start;
            oUNDERFLOW <= underflow || (oUNDERFLOW && !iUNDERFLOW_CLR);
            pop_q <= show;
            pat_q <= pattern && active ? hcount[7:0] ^ vcount[7:0] : 8'h00;
        end
    end
endmodule

// File: tb/tb_sdram_vga_fifo_reader.sv
// tb_sdram_vga_fifo_reader: randomized FIFO/filler environment with a position-based reference model.
module tb_sdram_vga_fifo_reader;
    localparam int HA = 32, HF = 4, HSW = 6, HB = 10, HT = HA + HF + HSW + HB;
    localparam int VA = 12, VF = 1, VSW = 3, VB = 2, VT = VA + VF + VSW + VB;
    logic clk = 0, rst = 0, empty = 1, uf_clr = 0, pat = 0, fill_en = 0, req_prev = 0;
    logic [7:0] rdata = 0, pix, exp_pix = 0;
    logic rden, req, hs, vs, blank_n, fs, uf, exp_uf = 0;
    logic [12:0] line, exp_line = 0;
    logic [7:0] q[$];
    int vectors = 0, errors = 0, cyc = 0, starve = 0;

    always #5 clk = ~clk;

    sdram_vga_fifo_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clock_fifowriter(clk), .iRST(rst), .iFIFO_RDATA(rdata), .iFIFO_EMPTY(empty),
        .oFIFO_RDEN(rden), .oVGA_LINE_TO_LOAD(line), .oVGA_LOAD_TO_FIFO_REQ(req),
        .oVGA_PIXEL(pix), .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blank_n),
        .oFRAME_START(fs), .oUNDERFLOW(uf), .iUNDERFLOW_CLR(uf_clr)
`ifdef VGA_FIFO_TEST_PATTERN_EN
        , .iPATTERN_SEL(pat)
`endif
    );

    // Screen position of the counters after c clock edges since reset release.
    function automatic int hp(int c); return (c + (VT - 1) * HT) % HT; endfunction
    function automatic int vp(int c); return ((c + (VT - 1) * HT) / HT) % VT; endfunction
    function automatic bit act_at(int c); return hp(c) < HA && vp(c) < VA; endfunction
    function automatic bit hs_at(int c); return hp(c) >= HA + HF && hp(c) < HA + HF + HSW; endfunction
    function automatic bit vs_at(int c); return vp(c) >= VA + VF && vp(c) < VA + VF + VSW; endfunction
    function automatic bit req_at(int c);
        return (hp(c) == HA || hp(c) == HA + 1) && (vp(c) < VA - 1 || vp(c) == VT - 1);
    endfunction

    task automatic step();
        logic dut_pop, was_empty, clr, was_pat, mact;
        logic [7:0] head, pat_px;
        dut_pop = rden; was_empty = empty; clr = uf_clr; was_pat = pat; mact = act_at(cyc);
        head = q.size() > 0 ? q[0] : 8'h00;
        pat_px = 8'(hp(cyc) ^ vp(cyc));
        @(posedge clk); #1;
        cyc++;
        if (dut_pop && !was_empty) rdata = q.pop_front();
        exp_pix = !mact ? 8'h00 : was_pat ? pat_px : was_empty ? 8'h00 : head;
        exp_uf = (mact && was_empty && !was_pat) || (exp_uf && !clr);
        if (hp(cyc) == HA && req_at(cyc)) exp_line = vp(cyc) == VT - 1 ? 13'd0 : 13'(vp(cyc) + 1);
        if (fill_en && req && !req_prev) repeat (HA) q.push_back(8'($urandom));
        req_prev = req;
        if (starve > 0) starve--;
        empty = q.size() == 0 || starve > 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 0; cyc = 0; exp_line = 0; exp_pix = 0; exp_uf = 0; req_prev = 0; starve = 0;
        empty = q.size() == 0;
        #1;
    endtask

    task automatic seek(int h, int v);
        int n = 0;
        while (!(hp(cyc) == h && vp(cyc) == v) && n < 3 * VT * HT) begin step(); n++; end
        vectors++;
        if (hp(cyc) != h || vp(cyc) != v) begin errors++; $display("FAIL seek: never reached h=%0d v=%0d", h, v); end
    endtask

    task automatic check_all_zero(string tag);
        vectors++;
        if ({rden, req, line, pix, hs, vs, blank_n, fs, uf} !== '0) begin
            errors++;
            $display("FAIL %s outputs: rden=%b req=%b line=%0d pix=%0h hs=%b vs=%b blank_n=%b fs=%b uf=%b, all required 0",
                     tag, rden, req, line, pix, hs, vs, blank_n, fs, uf);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1; #1;
        check_all_zero("reset");
        vectors++;
        if (uf !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b need 0", uf); end
        #20 release_reset();
    endtask

    task automatic test_first_request();
        int n = 0, req_cyc = -1;
        fill_en = 1;
        while (!req && n < 2 * HT) begin step(); n++; end
        req_cyc = cyc;
        vectors++;
        if (req_cyc !== HA) begin errors++; $display("FAIL first_req_cycle: got %0d need %0d", req_cyc, HA); end
        vectors++;
        if (line !== 13'd0) begin errors++; $display("FAIL first_req_line: got %0d need 0", line); end
        step();
        vectors++;
        if (req !== 1'b1) begin errors++; $display("FAIL first_req_width2: got %b need 1", req); end
        step();
        vectors++;
        if (req !== 1'b0) begin errors++; $display("FAIL first_req_drop: got %b need 0", req); end
        n = 0;
        while (!fs && n < 2 * HT) begin step(); n++; end
        vectors++;
        if (cyc - req_cyc !== HT + 1 - HA) begin
            errors++; $display("FAIL frame_start_delay: got %0d need %0d", cyc - req_cyc, HT + 1 - HA);
        end
    endtask

    task automatic test_frame();
        int nblank = 0, nrden = 0, hs_run = 0, hs_len = -1, vs_len = 0;
        logic rq = 0;
        logic [12:0] lines[$];
        for (int i = 0; i < VT * HT; i++) begin
            step();
            vectors += 9;
            if (rden !== ((act_at(cyc) || vs_at(cyc)) && !empty)) begin errors++; $display("FAIL rden c=%0d: got %b", cyc, rden); end
            if (blank_n !== act_at(cyc - 1)) begin errors++; $display("FAIL blank_n c=%0d: got %b", cyc, blank_n); end
            if (hs !== hs_at(cyc - 1)) begin errors++; $display("FAIL hs c=%0d: got %b", cyc, hs); end
            if (vs !== vs_at(cyc - 1)) begin errors++; $display("FAIL vs c=%0d: got %b", cyc, vs); end
            if (fs !== (hp(cyc - 1) == 0 && vp(cyc - 1) == 0)) begin errors++; $display("FAIL fs c=%0d: got %b", cyc, fs); end
            if (req !== req_at(cyc)) begin errors++; $display("FAIL req c=%0d: got %b", cyc, req); end
            if (line !== exp_line) begin errors++; $display("FAIL line c=%0d: got %0d need %0d", cyc, line, exp_line); end
            if (pix !== exp_pix) begin errors++; $display("FAIL pixel c=%0d: got %0h need %0h", cyc, pix, exp_pix); end
            if (uf !== exp_uf) begin errors++; $display("FAIL uf c=%0d: got %b need %b", cyc, uf, exp_uf); end
            if (req && !rq) lines.push_back(line);
            rq = req;
            nblank += int'(blank_n); nrden += int'(rden); vs_len += int'(vs);
            if (hs) hs_run++;
            else if (hs_run > 0) begin if (hs_len < 0) hs_len = hs_run; hs_run = 0; end
        end
        vectors++;
        if (lines.size() != VA) begin errors++; $display("FAIL req_count: got %0d need %0d", lines.size(), VA); end
        for (int k = 0; k < lines.size(); k++) begin
            vectors++;
            if (lines[k] !== 13'((k + 1) % VA)) begin errors++; $display("FAIL req_line[%0d]: got %0d need %0d", k, lines[k], (k + 1) % VA); end
        end
        vectors += 4;
        if (nblank != VA * HA) begin errors++; $display("FAIL blank_total: got %0d need %0d", nblank, VA * HA); end
        if (nrden != VA * HA) begin errors++; $display("FAIL rden_total: got %0d need %0d", nrden, VA * HA); end
        if (hs_len != HSW) begin errors++; $display("FAIL hs_width: got %0d need %0d", hs_len, HSW); end
        if (vs_len != VSW * HT) begin errors++; $display("FAIL vs_width: got %0d need %0d", vs_len, VSW * HT); end
    endtask

    task automatic test_underflow();
        int n = 0, flushed = 0;
        seek(5, 2);
        starve = 5; empty = 1; #1;
        while (!(vp(cyc) == VA + VF + VSW && hp(cyc) == 0) && n < 2 * VT * HT) begin
            step(); n++;
            vectors += 3;
            if (rden !== ((act_at(cyc) || vs_at(cyc)) && !empty)) begin errors++; $display("FAIL uf_rden c=%0d: got %b", cyc, rden); end
            if (pix !== exp_pix) begin errors++; $display("FAIL uf_pixel c=%0d: got %0h need %0h", cyc, pix, exp_pix); end
            if (uf !== exp_uf) begin errors++; $display("FAIL uf_flag c=%0d: got %b need %b", cyc, uf, exp_uf); end
            if (rden && vs_at(cyc)) flushed++;
        end
        vectors += 3;
        if (uf !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b need 1", uf); end
        if (flushed != 5) begin errors++; $display("FAIL flush_count: got %0d need 5", flushed); end
        if (q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d bytes left, need 0", q.size()); end
        seek(10, 1);
        starve = 1; empty = 1; uf_clr = 1; #1;
        step();
        vectors++;
        if (uf !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b need 1", uf); end
        step();
        vectors++;
        if (uf !== 1'b0) begin errors++; $display("FAIL clr: got %b need 0", uf); end
        uf_clr = 0;
    endtask

    task automatic test_reset_mid_line();
        seek(10, 3);
        #2 rst = 1; #1;
        check_all_zero("mid_reset");
        #15 release_reset();
        test_first_request();
    endtask

`ifdef VGA_FIFO_TEST_PATTERN_EN
    task automatic test_pattern();
        int n = 0;
        pat = 1; #1;
        while (!(hp(cyc) == 3 && vp(cyc) == 5) && n < 3 * VT * HT) begin
            step(); n++;
            vectors++;
            if (rden !== 1'b0) begin errors++; $display("FAIL pat_rden c=%0d: got %b need 0", cyc, rden); end
        end
        step();
        vectors += 2;
        if (pix !== 8'd6) begin errors++; $display("FAIL pat_pixel: got %0d need 6", pix); end
        if (pix !== exp_pix) begin errors++; $display("FAIL pat_model: got %0h need %0h", pix, exp_pix); end
        pat = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_request();
        test_frame();
        test_underflow();
        test_reset_mid_line();
`ifdef VGA_FIFO_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
